// File: rtl/branch_ctrl.sv
// ---------------------------------------------------------------------------
// branch_ctrl
//   Branch/call/return control unit. Evaluates a conditional branch against a
//   stored condition-code flag register and the ALU compare results, looks up
//   branch/call targets in a writable target table, and keeps return
//   addresses on a small return stack.
//
// Ports
//   clk                 single clock, all state changes on posedge
//   reset               asynchronous active-low reset
//   equal, less         ALU compare results for the current instruction
//   w_flag, flag_in     load a new condition code into the flag register
//   branch_instr        conditional branch
//   call_instr          unconditional call (pushes pc_next)
//   ret_instr           return (pops the return stack)
//   immediate           target-table index
//   pc_next             return address pushed on a call
//   tbl_we/waddr/wdata  target-table write port
//   address             branch target
//   branch              take the branch this cycle
//   stack_full/empty    return-stack status
//   stack_err           sticky overflow/underflow indicator
// ---------------------------------------------------------------------------
module branch_ctrl #(
   parameter int ADDR_W      = 10,
   parameter int IMM_W       = 5,
   parameter int FLAG_W      = 3,
   parameter int STACK_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              equal,
   input  logic              less,
   input  logic              w_flag,
   input  logic [FLAG_W-1:0] flag_in,
   input  logic              branch_instr,
   input  logic              call_instr,
   input  logic              ret_instr,
   input  logic [IMM_W-1:0]  immediate,
   input  logic [ADDR_W-1:0] pc_next,
   input  logic              tbl_we,
   input  logic [IMM_W-1:0]  tbl_waddr,
   input  logic [ADDR_W-1:0] tbl_wdata,
   output logic [ADDR_W-1:0] address,
   output logic              branch,
   output logic              stack_full,
   output logic              stack_empty,
   output logic              stack_err
);

   localparam int TBL_N = 2 ** IMM_W;
   localparam int PTR_W = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(STACK_DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   // Condition codes held in flag bits [2:0]
   localparam logic [2:0] CC_NE     = 3'b000;
   localparam logic [2:0] CC_EQ     = 3'b001;
   localparam logic [2:0] CC_LT     = 3'b010;
   localparam logic [2:0] CC_LE     = 3'b011;
   localparam logic [2:0] CC_ALWAYS = 3'b100;
   localparam logic [2:0] CC_GE     = 3'b101;
   localparam logic [2:0] CC_GT     = 3'b110;
   localparam logic [2:0] CC_NEVER  = 3'b111;

   logic [FLAG_W-1:0] flag_q, flag_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] tbl_q   [TBL_N];
   logic [ADDR_W-1:0] tbl_d   [TBL_N];
   logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
   logic [ADDR_W-1:0] stack_d [STACK_DEPTH];

   logic              cond_ok;
   logic              push, pop, err_set;
   logic              branch_c;
   logic [ADDR_W-1:0] addr_c;
   logic [IDX_W-1:0]  top_idx;
   logic [IDX_W-1:0]  push_idx;
   logic              is_full, is_empty;

   assign is_empty = (ptr_q == '0);
   assign is_full  = (ptr_q == PTR_FULL);

   // Pointer counts occupied entries: top lives one below it, and the next
   // push lands exactly at it (only used while not full, so it fits).
   assign top_idx  = IDX_W'(ptr_q - PTR_ONE);
   assign push_idx = IDX_W'(ptr_q);

   always_comb begin
      cond_ok = 1'b0;
      unique case (flag_q[2:0])
         CC_NE:     cond_ok = !equal;
         CC_EQ:     cond_ok = equal;
         CC_LT:     cond_ok = less;
         CC_LE:     cond_ok = less | equal;
         CC_ALWAYS: cond_ok = 1'b1;
         CC_GE:     cond_ok = !less;
         CC_GT:     cond_ok = !less & !equal;
         CC_NEVER:  cond_ok = 1'b0;
         default:   cond_ok = 1'b0;
      endcase
   end

   // Instruction decode: ret outranks call outranks branch.
   // Table read is combinational from the registered table, so a same-cycle
   // write to the indexed entry is not yet visible.
   always_comb begin
      push     = 1'b0;
      pop      = 1'b0;
      err_set  = 1'b0;
      branch_c = 1'b0;
      addr_c   = tbl_q[immediate];
      if (ret_instr) begin
         if (is_empty) begin
            err_set = 1'b1;
            addr_c  = '0;
         end else begin
            pop      = 1'b1;
            branch_c = 1'b1;
            addr_c   = stack_q[top_idx];
         end
      end else if (call_instr) begin
         branch_c = 1'b1;
         if (is_full) begin
            err_set = 1'b1;
         end else begin
            push = 1'b1;
         end
      end else if (branch_instr) begin
         branch_c = cond_ok;
      end
   end

   always_comb begin
      flag_d = flag_q;
      if (w_flag) begin
         flag_d = flag_in;
      end

      ptr_d = ptr_q;
      if (push) begin
         ptr_d = ptr_q + PTR_ONE;
      end else if (pop) begin
         ptr_d = ptr_q - PTR_ONE;
      end

      err_d = err_q | err_set;

      stack_d = stack_q;
      if (push) begin
         stack_d[push_idx] = pc_next;
      end

      tbl_d = tbl_q;
      if (tbl_we) begin
         tbl_d[tbl_waddr] = tbl_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flag_q <= '0;
         ptr_q  <= '0;
         err_q  <= 1'b0;
         for (int i = 0; i < TBL_N; i++) begin
            tbl_q[i] <= '0;
         end
         for (int i = 0; i < STACK_DEPTH; i++) begin
            stack_q[i] <= '0;
         end
      end else begin
         flag_q  <= flag_d;
         ptr_q   <= ptr_d;
         err_q   <= err_d;
         tbl_q   <= tbl_d;
         stack_q <= stack_d;
      end
   end

   // A call during reset would otherwise still drive branch high, so the
   // outputs are forced idle while reset is held.
   assign branch      = reset & branch_c;
   assign address     = reset ? addr_c : '0;
   assign stack_full  = is_full;
   assign stack_empty = is_empty;
   assign stack_err   = err_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_ctrl
//   Directed bench for branch_ctrl with a queue/array reference model and a
//   per-cycle compare process, plus hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_branch_ctrl;

   localparam int ADDR_W      = 10;
   localparam int IMM_W       = 5;
   localparam int FLAG_W      = 3;
   localparam int STACK_DEPTH = 4;

   logic              clk;
   logic              reset;
   logic              equal, less, w_flag;
   logic [FLAG_W-1:0] flag_in;
   logic              branch_instr, call_instr, ret_instr;
   logic [IMM_W-1:0]  immediate;
   logic [ADDR_W-1:0] pc_next;
   logic              tbl_we;
   logic [IMM_W-1:0]  tbl_waddr;
   logic [ADDR_W-1:0] tbl_wdata;
   logic [ADDR_W-1:0] address;
   logic              branch, stack_full, stack_empty, stack_err;

   branch_ctrl #(
      .ADDR_W(ADDR_W), .IMM_W(IMM_W), .FLAG_W(FLAG_W), .STACK_DEPTH(STACK_DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .equal(equal), .less(less),
      .w_flag(w_flag), .flag_in(flag_in),
      .branch_instr(branch_instr), .call_instr(call_instr), .ret_instr(ret_instr),
      .immediate(immediate), .pc_next(pc_next),
      .tbl_we(tbl_we), .tbl_waddr(tbl_waddr), .tbl_wdata(tbl_wdata),
      .address(address), .branch(branch),
      .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int                m_stack[$];
   logic [ADDR_W-1:0] m_tbl [2**IMM_W];
   logic [2:0]        m_flag;
   bit                m_err;

   function automatic bit cond_ok(logic [2:0] c, bit eq, bit lt);
      case (c)
         3'd0:    return !eq;
         3'd1:    return eq;
         3'd2:    return lt;
         3'd3:    return lt || eq;
         3'd4:    return 1'b1;
         3'd5:    return !lt;
         3'd6:    return !lt && !eq;
         default: return 1'b0;
      endcase
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_stack.delete();
         for (int i = 0; i < 2**IMM_W; i++) m_tbl[i] <= '0;
         m_flag <= '0;
         m_err  <= 1'b0;
      end else begin
         if (tbl_we) m_tbl[tbl_waddr] <= tbl_wdata;
         if (w_flag) m_flag <= flag_in[2:0];
         if (ret_instr) begin
            if (m_stack.size() == 0) m_err <= 1'b1;
            else void'(m_stack.pop_back());
         end else if (call_instr) begin
            if (m_stack.size() == STACK_DEPTH) m_err <= 1'b1;
            else m_stack.push_back(int'(pc_next));
         end
      end
   end

   // ---------------- literal expectations set by the stimulus ----------------
   bit    lit_on;
   string lit_name;
   int    lit_br, lit_addr, lit_full, lit_empty, lit_err;

   int tests, fails, cyc;

   task automatic chk(string nm, int act, int expv);
      tests++;
      if (act != expv) begin
         fails++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, expv);
      end
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      int eb, ea, ef, ee;
      cyc++;
      eb = 0;
      ea = 0;
      if (reset) begin
         ea = int'(m_tbl[immediate]);
         if (ret_instr) begin
            if (m_stack.size() == 0) ea = 0;
            else begin
               eb = 1;
               ea = m_stack[$];
            end
         end else if (call_instr) begin
            eb = 1;
         end else if (branch_instr) begin
            eb = int'(cond_ok(m_flag, equal, less));
         end
      end
      ef = (m_stack.size() == STACK_DEPTH) ? 1 : 0;
      ee = (m_stack.size() == 0) ? 1 : 0;
      chk("model_branch",  int'(branch),      eb);
      chk("model_address", int'(address),     ea);
      chk("model_full",    int'(stack_full),  ef);
      chk("model_empty",   int'(stack_empty), ee);
      chk("model_err",     int'(stack_err),   int'(m_err));
      if (lit_on) begin
         chk({lit_name, "_branch"},  int'(branch),      lit_br);
         chk({lit_name, "_address"}, int'(address),     lit_addr);
         chk({lit_name, "_full"},    int'(stack_full),  lit_full);
         chk({lit_name, "_empty"},   int'(stack_empty), lit_empty);
         chk({lit_name, "_err"},     int'(stack_err),   lit_err);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
      lit_on = 1'b0;
   endtask

   task automatic expect_lit(string nm, int b, int a, int f, int e, int er);
      lit_name  = nm;
      lit_br    = b;
      lit_addr  = a;
      lit_full  = f;
      lit_empty = e;
      lit_err   = er;
      lit_on    = 1'b1;
   endtask

   task automatic idle();
      equal = 0; less = 0; w_flag = 0; flag_in = '0;
      branch_instr = 0; call_instr = 0; ret_instr = 0;
      tbl_we = 0; tbl_waddr = '0; tbl_wdata = '0; pc_next = '0;
   endtask

   initial begin
      tests = 0; fails = 0; cyc = 0; lit_on = 0; lit_name = "";
      reset = 1'b0;
      idle();
      immediate = '0;
      // call asserted during reset must not show up on the outputs
      call_instr = 1; flag_in = 3'b100; w_flag = 1;
      expect_lit("reset", 0, 0, 0, 1, 0);
      tick();
      expect_lit("reset2", 0, 0, 0, 1, 0);
      tick();
      reset = 1'b1;
      idle();

      // table write and flag load; same-cycle read still sees old entry
      immediate = 3; tbl_we = 1; tbl_waddr = 3; tbl_wdata = 100;
      w_flag = 1; flag_in = 3'b001;
      expect_lit("wr_old", 0, 0, 0, 1, 0);
      tick();
      idle(); immediate = 3;
      branch_instr = 1; equal = 1;
      expect_lit("beq_taken", 1, 100, 0, 1, 0);
      tick();
      equal = 0;
      expect_lit("beq_not", 0, 100, 0, 1, 0);
      tick();

      // old flag used when flag load and branch share a cycle
      idle(); immediate = 3; w_flag = 1; flag_in = 3'b100;
      tick();
      w_flag = 1; flag_in = 3'b010; branch_instr = 1; less = 0;
      expect_lit("flag_old", 1, 100, 0, 1, 0);
      tick();
      w_flag = 0; branch_instr = 1; less = 0;
      expect_lit("flag_new", 0, 100, 0, 1, 0);
      tick();
      less = 1;
      tick();

      // sweep all condition codes against (eq,lt) combos
      for (int c = 0; c < 8; c++) begin
         idle(); immediate = 3; w_flag = 1; flag_in = 3'(c);
         tick();
         idle(); immediate = 3; branch_instr = 1;
         for (int k = 0; k < 3; k++) begin
            equal = (k == 1);
            less  = (k == 2);
            tick();
         end
      end

      // fill the return stack, then overflow
      idle(); immediate = 5; tbl_we = 1; tbl_waddr = 5; tbl_wdata = 200;
      tick();
      idle(); immediate = 5;
      for (int i = 0; i < 4; i++) begin
         call_instr = 1; pc_next = ADDR_W'(10 + i);
         if (i == 0) expect_lit("call_first", 1, 200, 0, 1, 0);
         tick();
      end
      call_instr = 1; pc_next = 14;
      expect_lit("call_full", 1, 200, 1, 0, 0);
      tick();
      idle(); immediate = 5;
      expect_lit("overflow_err", 0, 200, 1, 0, 1);
      tick();
      for (int i = 0; i < 4; i++) begin
         ret_instr = 1;
         expect_lit("ret_pop", 1, 13 - i, (i == 0) ? 1 : 0, 0, 1);
         tick();
      end
      ret_instr = 1;
      expect_lit("ret_empty", 0, 0, 0, 1, 1);
      tick();
      idle(); immediate = 5; call_instr = 1; pc_next = 20;
      expect_lit("err_sticky", 1, 200, 0, 1, 1);
      tick();
      call_instr = 1; ret_instr = 1; pc_next = 99;
      expect_lit("ret_over_call", 1, 20, 0, 0, 1);
      tick();
      idle(); immediate = 5;
      expect_lit("no_push", 0, 200, 0, 1, 1);
      tick();

      // table write and call together
      immediate = 7; tbl_we = 1; tbl_waddr = 7; tbl_wdata = 300;
      call_instr = 1; pc_next = 33;
      expect_lit("wr_call", 1, 0, 0, 1, 1);
      tick();
      idle(); immediate = 7; ret_instr = 1;
      expect_lit("wr_call_ret", 1, 33, 0, 0, 1);
      tick();
      idle(); immediate = 7;
      tick();

      // three pushes, then reset between edges with a call pending
      idle(); immediate = 3;
      for (int i = 0; i < 3; i++) begin
         call_instr = 1; pc_next = ADDR_W'(40 + i);
         tick();
      end
      call_instr = 1; pc_next = 50;
      reset = 1'b0;
      #1;
      expect_lit("async_rst", 0, 0, 0, 1, 0);
      tick();
      reset = 1'b1;
      idle(); immediate = 3;
      expect_lit("post_rst", 0, 0, 0, 1, 0);
      tick();
      ret_instr = 1;
      expect_lit("post_rst_ret", 0, 0, 0, 1, 0);
      tick();
      idle(); immediate = 3; branch_instr = 1;
      tick();
      idle();
      tick();
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
